// File: rtl/ervp_seq_multiplier.sv
// Sequential shift-and-add multiplier, signed/unsigned, one partial product per cycle.
// Define ERVP_SEQ_MULTIPLIER_EARLY_EXIT_EN to stop as soon as the multiplier runs out of set bits.
module ervp_seq_multiplier #(
    parameter int BW_DATA = 32
) (
    input  logic               clk,
    input  logic               rstnn,
    input  logic               enable,
    output logic               busy,
    input  logic               start,
    input  logic               is_unsigned,
    input  logic [BW_DATA-1:0] multiplicand,
    input  logic [BW_DATA-1:0] multiplier,
    output logic [BW_DATA-1:0] product_high,
    output logic [BW_DATA-1:0] product_low,
    output logic               done
);

    localparam int BW_PROD = 2 * BW_DATA;
    localparam int BW_CNT  = $clog2(BW_DATA + 1);

    localparam logic [BW_DATA-1:0] DATA_ONE = BW_DATA'(1);
    localparam logic [BW_PROD-1:0] PROD_ONE = BW_PROD'(1);
    localparam logic [BW_CNT-1:0]  CNT_ONE  = BW_CNT'(1);
    localparam logic [BW_CNT-1:0]  CNT_INIT = BW_CNT'(BW_DATA);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t               state, state_n;
    logic [BW_PROD-1:0]   acc, acc_n;
    logic [BW_PROD-1:0]   mcand, mcand_n;
    logic [BW_DATA-1:0]   mplier, mplier_n;
    logic [BW_CNT-1:0]    count, count_n;
    logic                 sign, sign_n;
    logic [BW_PROD-1:0]   product, product_n;
    logic                 done_r, done_n;

    logic [BW_DATA-1:0]   mag_a, mag_b;
    logic [BW_PROD-1:0]   addend, acc_sum;
    logic [BW_DATA-1:0]   mplier_shr;
    logic                 last;

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            sign    <= 1'b0;
            product <= '0;
            done_r  <= 1'b0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            mcand   <= mcand_n;
            mplier  <= mplier_n;
            count   <= count_n;
            sign    <= sign_n;
            product <= product_n;
            done_r  <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        acc_n     = acc;
        mcand_n   = mcand;
        mplier_n  = mplier;
        count_n   = count;
        sign_n    = sign;
        product_n = product;
        done_n    = 1'b0;

        // Negating the most negative value wraps back to itself, which read
        // as unsigned is exactly 2^(BW_DATA-1).
        mag_a = (!is_unsigned && multiplicand[BW_DATA-1])
              ? (~multiplicand + DATA_ONE) : multiplicand;
        mag_b = (!is_unsigned && multiplier[BW_DATA-1])
              ? (~multiplier + DATA_ONE) : multiplier;

        addend     = mplier[0] ? mcand : '0;
        acc_sum    = acc + addend;
        mplier_shr = mplier >> 1;

`ifdef ERVP_SEQ_MULTIPLIER_EARLY_EXIT_EN
        last = (mplier_shr == '0) || (count == CNT_ONE);
`else
        last = (count == CNT_ONE);
`endif

        if (enable) begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sign_n = ~is_unsigned &
                                 (multiplicand[BW_DATA-1] ^ multiplier[BW_DATA-1]);
                        if (mag_a == '0 || mag_b == '0) begin
                            product_n = '0;
                            done_n    = 1'b1;
                        end else begin
                            state_n  = RUN;
                            acc_n    = '0;
                            mcand_n  = {{BW_DATA{1'b0}}, mag_a};
                            mplier_n = mag_b;
                            count_n  = CNT_INIT;
                        end
                    end
                end
                RUN: begin
                    acc_n    = acc_sum;
                    mcand_n  = mcand << 1;
                    mplier_n = mplier_shr;
                    count_n  = count - CNT_ONE;
                    if (last) begin
                        state_n   = IDLE;
                        product_n = sign ? (~acc_sum + PROD_ONE) : acc_sum;
                        done_n    = 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy         = (state == RUN);
    assign done         = done_r;
    assign product_high = product[BW_PROD-1:BW_DATA];
    assign product_low  = product[BW_DATA-1:0];

endmodule

// File: tb/tb_ervp_seq_multiplier.sv
// Scoreboard bench for ervp_seq_multiplier: directed corner cases plus random
// operands, checked against plain-arithmetic reference products.
module tb_ervp_seq_multiplier;

    localparam int W = 32;
    localparam int P = 2 * W;

    logic         clk = 1'b0;
    logic         rstnn = 1'b0;
    logic         enable = 1'b0;
    logic         start = 1'b0;
    logic         is_unsigned = 1'b0;
    logic [W-1:0] multiplicand = '0;
    logic [W-1:0] multiplier = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] product_high;
    logic [W-1:0] product_low;

    int checks = 0;
    int errors = 0;
    logic [P-1:0] exp_q[$];
    logic [P-1:0] last_prod;

    ervp_seq_multiplier #(.BW_DATA(W)) dut (
        .clk(clk),
        .rstnn(rstnn),
        .enable(enable),
        .busy(busy),
        .start(start),
        .is_unsigned(is_unsigned),
        .multiplicand(multiplicand),
        .multiplier(multiplier),
        .product_high(product_high),
        .product_low(product_low),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [P-1:0] act,
                       input logic [P-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic uns);
        logic [W-1:0] r;
        r = x;
        if (!uns && x[W-1]) r = -x;
        return r;
    endfunction

    function automatic int msb_idx(input logic [W-1:0] x);
        int r;
        r = -1;
        for (int i = 0; i < W; i++) if (x[i]) r = i;
        return r;
    endfunction

    function automatic logic [P-1:0] ref_prod(input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input logic uns);
        logic signed [P-1:0] sa, sb;
        logic [P-1:0] ua, ub;
        ua = {{W{1'b0}}, a};
        ub = {{W{1'b0}}, b};
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        if (uns) return ua * ub;
        return P'(sa * sb);
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rstnn === 1'b1 && done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 required no pending op");
                end else begin
                    chk("product", {product_high, product_low}, exp_q.pop_front());
                end
            end
        end
    end

    // Caller must be at a negedge; returns at the negedge where done is seen,
    // so a following call exercises start in the done cycle.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic uns, input logic [P-1:0] expect_p,
                      input int stall_at, input int start_at);
        logic [W-1:0] mb;
        int exp_lat, exp_busy, busy_cnt;
        bit seen;
        mb = mag(b, uns);
        if (mag(a, uns) == '0 || mb == '0) begin
            exp_busy = 0;
        end else begin
`ifdef ERVP_SEQ_MULTIPLIER_EARLY_EXIT_EN
            exp_busy = msb_idx(mb) + 1;
`else
            exp_busy = W;
`endif
        end
        if (stall_at < 1 || stall_at >= exp_busy) stall_at = -100;
        else exp_busy += 10;
        exp_lat = exp_busy + 1;
        multiplicand = a;
        multiplier   = b;
        is_unsigned  = uns;
        start        = 1'b1;
        exp_q.push_back(expect_p);
        @(posedge clk);
        #1 start = 1'b0;
        busy_cnt = 0;
        seen = 0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (stall_at > 0 && n > stall_at && n <= stall_at + 10) begin
                chk("stall_busy", P'(busy), P'(1));
                chk("stall_no_done", P'(done), P'(0));
            end
            if (done === 1'b1) begin
                seen = 1;
                chk("latency", P'(n), P'(exp_lat));
                chk("busy_cycles", P'(busy_cnt), P'(exp_busy));
                last_prod = expect_p;
                break;
            end
            start = 1'b0;
            if (n == stall_at) enable = 1'b0;
            if (n == stall_at + 10) enable = 1'b1;
            if (n == start_at && busy === 1'b1) begin
                start = 1'b1;
                multiplicand = ~a;
                multiplier = b + 1;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            enable = 1'b1;
            $display("FAIL done_timeout: got no done required done within 300 cycles");
        end
    endtask

    task automatic idle_hold(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("hold_product", {product_high, product_low}, last_prod);
        end
    endtask

    initial begin
        logic [W-1:0] a, b;
        logic uns;
        int stall;

        repeat (2) @(negedge clk);
        chk("reset_busy", P'(busy), P'(0));
        chk("reset_done", P'(done), P'(0));
        chk("reset_product", {product_high, product_low}, '0);
        rstnn  = 1'b1;
        enable = 1'b1;
        @(negedge clk);

        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001, 0, 0);
        op(-32'sd3, 32'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB, 0, 0);
        op(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, 0, 0);
        idle_hold(3);
        op(32'd0, 32'd5, 1'b1, 64'h0, 0, 0);
        op(32'hDEAD_BEEF, 32'd0, 1'b0, 64'h0, 0, 0);
        op(32'd6, 32'd3, 1'b1, 64'd18, 0, 0);
        op(32'd1, 32'h8000_0000, 1'b1, 64'h8000_0000, 0, 0);
        op(32'h8000_0000, 32'd1, 1'b0, 64'hFFFF_FFFF_8000_0000, 0, 0);
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'd1, 0, 0);
        op(32'd1000, 32'd12345, 1'b1, 64'd12345000, 0, 5);
        op(-32'sd1000, 32'h7FFF_FFFF, 1'b0,
           ref_prod(-32'sd1000, 32'h7FFF_FFFF, 1'b0), 7, 0);
        idle_hold(2);

        // Reset mid-run: operation aborted, outputs cleared, no done.
        multiplicand = 32'd77;
        multiplier   = 32'hFFFF_0000;
        is_unsigned  = 1'b1;
        start        = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rstnn  = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy", P'(busy), P'(0));
        chk("abort_done", P'(done), P'(0));
        chk("abort_product", {product_high, product_low}, '0);
        rstnn  = 1'b1;
        enable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", P'(done), P'(0));
        end

        op(32'd9, -32'sd9, 1'b0, 64'hFFFF_FFFF_FFFF_FFAF, 0, 0);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: a = '0;
                1: b = 32'h8000_0000;
                2: b = b >> $urandom_range(0, 31);
                3: a = 32'h8000_0000;
                default: ;
            endcase
            uns = 1'($urandom_range(0, 1));
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
            op(a, b, uns, ref_prod(a, b, uns), stall,
               ($urandom_range(0, 3) == 0) ? 3 : 0);
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pending_results: got %0d left required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ervp_seq_multiplier.md
ERVP_SEQ_MULTIPLIER -- requirements
Module: ervp_seq_multiplier

Interface
REQ-001 SHALL have parameter BW_DATA, default 32, operand width in bits, minimum 2.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rstnn, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port enable, input, 1, global advance; when low, all state holds.
REQ-005 SHALL have port busy, output, 1, high while an iteration sequence runs.
REQ-006 SHALL have port start, input, 1, request to begin a multiplication.
REQ-007 SHALL have port is_unsigned, input, 1; 1 means unsigned operands, 0 means two's-complement operands.
REQ-008 SHALL have ports multiplicand and multiplier, input, BW_DATA each, the operands.
REQ-009 SHALL have ports product_high and product_low, output, BW_DATA each, the upper and lower halves of the 2*BW_DATA-bit product.
REQ-010 SHALL have port done, output, 1, single-cycle pulse when a new product is valid.

Function
REQ-011 SHALL implement states IDLE and RUN; transitions occur only in cycles where enable=1.
REQ-012 IDLE with start=1 SHALL accept operands; start in RUN SHALL be ignored.
REQ-013 Signed mode SHALL take operand magnitudes and record sign = msb(multiplicand) XOR msb(multiplier); unsigned mode sign = 0.
REQ-014 Magnitude of the most negative value (e.g. 0x80000000) SHALL be treated as unsigned 2^(BW_DATA-1).
REQ-015 If either magnitude is zero on accept, the block SHALL stay in IDLE, load product 0, and pulse done the next cycle; busy SHALL stay low.
REQ-016 Otherwise the block SHALL enter RUN with accumulator 0, a 2*BW_DATA-bit shifted-multiplicand register = |multiplicand|, and a multiplier register = |multiplier|.
REQ-017 Each RUN cycle SHALL add the shifted multiplicand to the accumulator if multiplier-register bit 0 = 1, shift the multiplicand left by 1, and shift the multiplier right by 1.
REQ-018 Without early exit, RUN SHALL last exactly BW_DATA cycles, counted by a counter loaded on accept.
REQ-019 On leaving RUN, the block SHALL return to IDLE and pulse done for one cycle.
REQ-020 The product outputs SHALL equal the accumulator when sign=0 and its two's-complement negation when sign=1.
REQ-021 Latency from the accept edge to done, without early exit, SHALL be BW_DATA+1 cycles.
REQ-022 product_high and product_low SHALL hold the last result until the next accepted start.
REQ-023 The product SHALL be exact modulo 2^(2*BW_DATA); overflow is impossible.
REQ-024 enable=0 mid-RUN SHALL freeze the counter, registers, and busy; done SHALL NOT pulse while enable=0.
REQ-025 start coinciding with the done cycle SHALL be accepted, since the state is IDLE.

Reset
REQ-026 rstnn=0 at a clock edge SHALL force IDLE, busy=0, done=0, product_high=0, product_low=0, sign=0, and counter=0, regardless of enable.
REQ-027 Reset during RUN SHALL abort the operation with no done pulse.
REQ-028 The first start after rstnn returns high SHALL be accepted normally.

Configuration
REQ-029 Macro ERVP_SEQ_MULTIPLIER_EARLY_EXIT_EN, when defined, SHALL end RUN at the cycle in which the next multiplier-register value is zero; RUN then lasts (index of the highest set bit of |multiplier|)+1 cycles.
REQ-030 When ERVP_SEQ_MULTIPLIER_EARLY_EXIT_EN is undefined, RUN SHALL always last BW_DATA cycles per REQ-018; results SHALL be identical in both builds.

Verification (BW_DATA=32)
REQ-031 Unsigned 0xFFFFFFFF*0xFFFFFFFF -> product 0xFFFFFFFE_00000001, busy high for 32 cycles (macro off), done at accept+33.
REQ-032 Signed -3*7 -> product_high 0xFFFFFFFF, product_low 0xFFFFFFEB; signed 0x80000000*0x80000000 -> 0x40000000_00000000.
REQ-033 Operands 0 and 5 -> busy never rises, done the next cycle, product 0; start asserted during RUN -> ignored, result unchanged.
REQ-034 Hold enable=0 for 10 cycles mid-RUN -> busy held, done delayed by 10 cycles, result correct; rstnn=0 mid-RUN -> outputs 0, no done pulse.
REQ-035 Macro on, unsigned 6*3 -> busy for 2 cycles, product 18; macro on, 1*0x80000000 -> busy for 32 cycles, product 0x80000000.
